// File: rtl/fb_pkg.sv
// Shared framebuffer constants, FSM encoding, FIFO entry layout and address packing
// for the pixel write path.
package fb_pkg;

    localparam int WIDTH    = 160;
    localparam int HEIGHT   = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int ENTRY_W  = ADDR_W + COLOUR_W;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_WRITE_ENC = 2'd1;
    localparam logic [1:0] ST_CLEAR_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_CLEAR = ST_CLEAR_ENC
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } fifo_entry_t;

    // A 160-wide screen maps to two shifts and an add; other widths fall back to a multiply.
    function automatic logic [ADDR_W-1:0] addr_pack(
        input logic [Y_W-1:0] y,
        input logic [X_W-1:0] x,
        input int             width
    );
        logic [ADDR_W-1:0] y_ext;
        logic [ADDR_W-1:0] x_ext;
        y_ext = ADDR_W'(y);
        x_ext = ADDR_W'(x);
        if (width == 160) begin
            return (y_ext << 7) + (y_ext << 5) + x_ext;
        end
        return y_ext * ADDR_W'(width) + x_ext;
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO holding packed plot requests; head is read combinationally.
// A push while full is accepted only when a pop happens in the same cycle.
module plot_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the count and pointers alone
    // decide which entries are valid, so clearing the array would only cost routing.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_write_ctrl.sv
// Plot-interface receiver: range-checks and queues plots, drives the framebuffer
// write port one pixel per cycle, runs full-screen clears and keeps drop/frame counts.
module pixel_write_ctrl
    import fb_pkg::*;
#(
    parameter int WIDTH  = fb_pkg::WIDTH,
    parameter int HEIGHT = fb_pkg::HEIGHT,
    parameter int DEPTH  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic                iPlot,
    input  logic                iDone,
    input  logic                iClear,
    input  logic [COLOUR_W-1:0] iClearColour,
    output logic [ADDR_W-1:0]   oAddr,
    output logic [COLOUR_W-1:0] oData,
    output logic                oWe,
    output logic                oBusy,
    output logic                oClearDone,
    output logic [7:0]          oDropCount,
    output logic [7:0]          oFrameCount
);

    localparam logic [X_W:0]      X_LIMIT   = (X_W+1)'(WIDTH);
    localparam logic [Y_W:0]      Y_LIMIT   = (Y_W+1)'(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t              state;
    logic [ADDR_W-1:0]   clear_addr;
    logic [COLOUR_W-1:0] clear_colour;
    logic                last_clear;

    fifo_entry_t push_entry;
    fifo_entry_t head_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        in_range;
    logic        pop;
    logic        push;
    logic        drop;

    // NOTE: every signal assigned here gets a default first, so no path can leave
    // a value unassigned and infer a latch.
    always_comb begin
        in_range = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        drop     = 1'b0;

        in_range = ({1'b0, iX} < X_LIMIT) && ({1'b0, iY} < Y_LIMIT);
        pop      = (state == ST_WRITE) && !fifo_empty;
        if (iPlot) begin
            if (in_range && (!fifo_full || pop)) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    assign push_entry = '{addr: addr_pack(iY, iX, WIDTH), colour: iColour};
    assign oBusy      = (state != ST_IDLE) || !fifo_empty;

    plot_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_plot_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // here samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_IDLE;
            clear_addr   <= '0;
            clear_colour <= '0;
            last_clear   <= 1'b0;
            oAddr        <= '0;
            oData        <= '0;
            oWe          <= 1'b0;
            oClearDone   <= 1'b0;
        end else begin
            oWe        <= 1'b0;
            last_clear <= 1'b0;
            oClearDone <= last_clear;

            case (state)
                ST_IDLE: begin
                    if (iClear) begin
                        state        <= ST_CLEAR;
                        clear_addr   <= '0;
                        clear_colour <= iClearColour;
                    end else if (!fifo_empty) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (fifo_empty) begin
                        state <= ST_IDLE;
                    end else begin
                        oAddr <= head_entry.addr;
                        oData <= head_entry.colour;
                        oWe   <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    oAddr <= clear_addr;
                    oData <= clear_colour;
                    oWe   <= 1'b1;
                    if (clear_addr == LAST_ADDR) begin
                        state      <= ST_IDLE;
                        last_clear <= 1'b1;
                    end else begin
                        clear_addr <= clear_addr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Drop count saturates; frame count wraps.
    always_ff @(posedge clock) begin
        if (!reset) begin
            oDropCount  <= '0;
            oFrameCount <= '0;
        end else begin
            if (drop && (oDropCount != 8'hFF)) begin
                oDropCount <= oDropCount + 1'b1;
            end
            if (iDone) begin
                oFrameCount <= oFrameCount + 1'b1;
            end
        end
    end

endmodule
